nios_system_hex_ctrl: RTL and testbench

Parametrised Avalon-MM slave driving up to eight active-low 7-segment displays from the Nios system bus. Software writes one hex nibble per digit and the block decodes it to segments. Per-digit blank and blink masks are supported, and a programmable blink timer is built in. It replaces the flat 32-bit output PIO on the hex display bus with a registered, glitch-free segment output.

---
 rtl/nios_system_hex_pkg.sv | 18 +
 rtl/nios_system_hex_seg7.sv | 11 +
 rtl/nios_system_hex_ctrl.sv | 118 +++++++++++
 tb/tb_nios_system_hex_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_hex_pkg.sv
// Shared constants for the hex display controller: register map, blank code
// and the active-low gfedcba glyph table.
package nios_system_hex_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_SET    = 2'd3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for hex digit n; index 15 is listed first.
  localparam logic [15:0][6:0] SEG7_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/nios_system_hex_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder (gfedcba).
module nios_system_hex_seg7
  import nios_system_hex_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7_GLYPH[i_nib];

endmodule

// File: rtl/nios_system_hex_ctrl.sv
// Avalon-MM hex display controller with per-digit blank/blink masks.
// Blink timer, PERIOD register and BLINK mask exist only when
// NIOS_SYSTEM_HEX_CTRL_BLINK_EN is defined.
module nios_system_hex_ctrl
  import nios_system_hex_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int PERIOD_W       = 26,
  parameter int DEFAULT_PERIOD = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*N_DIGITS-1:0]   out_port
);

  logic                    w_wr;
  logic [4*N_DIGITS-1:0]   r_data;
  logic [N_DIGITS-1:0]     r_blank;
  logic [N_DIGITS-1:0]     w_hide;
  logic [7*N_DIGITS-1:0]   w_seg_next;

  assign w_wr = chipselect && !write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_blank <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA: r_data  <= writedata[4*N_DIGITS-1:0];
        ADDR_SET:  r_data  <= r_data | writedata[4*N_DIGITS-1:0];
        ADDR_CTRL: r_blank <= writedata[N_DIGITS-1:0];
        default:   ;
      endcase
    end
  end

`ifdef NIOS_SYSTEM_HEX_CTRL_BLINK_EN
  logic [N_DIGITS-1:0] r_blink;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink <= '0;
    end else if (w_wr && address == ADDR_CTRL) begin
      r_blink <= writedata[8 +: N_DIGITS];
    end
  end

  // A PERIOD write outranks a coincident terminal count, so it restarts cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= PERIOD_W'(DEFAULT_PERIOD);
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (w_wr && address == ADDR_PERIOD) begin
      r_period <= writedata[PERIOD_W-1:0];
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (r_period == '0) begin
      r_cnt    <= '0;
      r_phase  <= 1'b1;
    end else if (r_cnt == r_period - PERIOD_W'(1)) begin
      r_cnt    <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_cnt    <= r_cnt + PERIOD_W'(1);
    end
  end

  assign w_hide = r_blank | (r_blink & {N_DIGITS{~r_phase}});
`else
  assign w_hide = r_blank;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[4*N_DIGITS-1:0] = r_data;
      ADDR_CTRL: begin
        readdata[N_DIGITS-1:0] = r_blank;
`ifdef NIOS_SYSTEM_HEX_CTRL_BLINK_EN
        readdata[8 +: N_DIGITS] = r_blink;
`endif
      end
`ifdef NIOS_SYSTEM_HEX_CTRL_BLINK_EN
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = r_period;
      ADDR_SET:    readdata[0] = r_phase;
`endif
      default: ;
    endcase
  end

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    logic [6:0] w_seg;
    nios_system_hex_seg7 u_seg7 (
      .i_nib (r_data[4*g +: 4]),
      .o_seg (w_seg)
    );
    assign w_seg_next[7*g +: 7] = w_hide[g] ? SEG_BLANK : w_seg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= {N_DIGITS{SEG7_GLYPH[0]}};
    end else begin
      out_port <= w_seg_next;
    end
  end

endmodule

// File: tb/tb_nios_system_hex_ctrl.sv
// Self-checking bench for nios_system_hex_ctrl: cycle model plus directed checks.
module tb_nios_system_hex_ctrl;

`ifdef NIOS_SYSTEM_HEX_CTRL_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif
  localparam int N = 8;
  localparam logic [55:0] ALL_ZERO_GLYPH = 56'h81020408102040;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [55:0] out_port;

  int checks = 0;
  int errors = 0;

  nios_system_hex_ctrl #(.N_DIGITS(N), .PERIOD_W(26), .DEFAULT_PERIOD(25000000)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain integer state following the register/timer rules.
  int unsigned glyph [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                              'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
  logic [31:0] m_data;
  logic [7:0]  m_blank, m_blink;
  int unsigned m_period, m_cnt;
  bit          m_phase;
  logic [55:0] exp_out;

  function automatic logic [55:0] show(logic [31:0] data, logic [7:0] blank,
                                       logic [7:0] blink, bit phase);
    logic [55:0] r;
    r = '0;
    for (int d = 0; d < N; d++) begin
      int unsigned nib;
      int unsigned s;
      nib = (data >> (4 * d)) & 32'hF;
      if (blank[d] || (blink[d] && !phase)) s = 'h7F;
      else s = glyph[nib];
      r = r | (56'(s) << (7 * d));
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_read(logic [1:0] a);
    case (a)
      2'd0: return m_data;
      2'd1: return {16'h0, m_blink, m_blank};
      2'd2: return m_period;
      default: return BLINK_EN ? 32'(m_phase) : 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data   <= '0;
      m_blank  <= '0;
      m_blink  <= '0;
      m_period <= BLINK_EN ? 25000000 : 0;
      m_cnt    <= 0;
      m_phase  <= 1'b1;
      exp_out  <= ALL_ZERO_GLYPH;
    end else begin
      exp_out <= show(m_data, m_blank, m_blink, m_phase);
      if (chipselect && !write_n) begin
        if (address == 2'd0) m_data <= writedata;
        if (address == 2'd3) m_data <= m_data | writedata;
        if (address == 2'd1) begin
          m_blank <= writedata[7:0];
          m_blink <= BLINK_EN ? writedata[15:8] : 8'h0;
        end
      end
      if (BLINK_EN) begin
        if (chipselect && !write_n && address == 2'd2) begin
          m_period <= writedata % (1 << 26);
          m_cnt    <= 0;
          m_phase  <= 1'b1;
        end else if (m_period == 0) begin
          m_cnt   <= 0;
          m_phase <= 1'b1;
        end else if (m_cnt + 1 == m_period) begin
          m_cnt   <= 0;
          m_phase <= !m_phase;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_out_port", 64'(out_port), 64'(exp_out));
    chk("model_readdata", 64'(readdata), 64'(exp_read(address)));
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, 64'(readdata), 64'(exp));
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  initial begin
    #12 reset_n = 1'b1;
    step();
    chk("reset_out_port", 64'(out_port), 64'(ALL_ZERO_GLYPH));
    rd_chk("reset_period", 2'd2, BLINK_EN ? 32'd25000000 : 32'd0);
    rd_chk("reset_phase", 2'd3, BLINK_EN ? 32'd1 : 32'd0);
    rd_chk("reset_ctrl", 2'd1, 32'd0);

    wr(2'd0, 32'h89ABCDEF);
    rd_chk("data_readback", 2'd0, 32'h89ABCDEF);
    step();
    chk("digit0_F", 64'(out_port[6:0]), 64'h0E);
    chk("digit7_8", 64'(out_port[55:49]), 64'h00);

    wr(2'd0, 32'h0);
    wr(2'd3, 32'h00000050);
    wr(2'd3, 32'h00000003);
    rd_chk("set_data", 2'd0, 32'h00000053);
    step();
    chk("set_digit0", 64'(out_port[6:0]), 64'h30);
    chk("set_digit1", 64'(out_port[13:7]), 64'h12);

    wr(2'd1, 32'h00000201);
    rd_chk("ctrl_readback", 2'd1, BLINK_EN ? 32'h201 : 32'h1);
    step();
    chk("blank_digit0", 64'(out_port[6:0]), 64'h7F);
    chk("phase1_digit1", 64'(out_port[13:7]), 64'h12);
    chk("other_digits", 64'(out_port[55:14]), 64'(ALL_ZERO_GLYPH[55:14]));

    wr(2'd1, 32'h00000101);
    wr(2'd2, 32'd4);
    rd_chk("period_readback", 2'd2, BLINK_EN ? 32'd4 : 32'd0);
    for (int i = 0; i < 12; i++) begin
      rd_chk("phase_seq", 2'd3, BLINK_EN ? 32'((i / 4) % 2 == 0) : 32'd0);
      step();
    end

    wr(2'd2, 32'd4);
    step(); step(); step();
    address = 2'd2; writedata = 32'd4; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_chk("tc_collision", 2'd3, BLINK_EN ? 32'(i < 4) : 32'd0);
      step();
    end

    wr(2'd2, 32'd0);
    for (int i = 0; i < 100; i++) begin
      rd_chk("period0_phase", 2'd3, BLINK_EN ? 32'd1 : 32'd0);
      step();
    end

    wr(2'd0, 32'h12345678);
    wr(2'd1, 32'h0000FF00);
    wr(2'd2, 32'd3);
    repeat (5) step();
    #1 reset_n = 1'b0;
    #1 chk("async_reset_out", 64'(out_port), 64'(ALL_ZERO_GLYPH));
    repeat (2) step();
    #1 reset_n = 1'b1;
    rd_chk("post_reset_data", 2'd0, 32'd0);
    rd_chk("post_reset_ctrl", 2'd1, 32'd0);
    rd_chk("post_reset_phase", 2'd3, BLINK_EN ? 32'd1 : 32'd0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
